// File: rtl/cpu_in_port.sv
// Board-input port: synchronizes and debounces up to 8 raw pins, then holds each
// settled change in a byte register for the CPU. Optional macro: INPORT_PRESS_ONLY_EN.
module cpu_in_port #(
   parameter int WIDTH   = 4,
   parameter int DB_BITS = 18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_pins,
   input  logic             rd,
   output logic [7:0]       data_out,
   output logic             valid,
   output logic             overrun,
   output logic             dbg_state
);

   // Handshake: valid=1 means data_out holds an unread byte; a single-cycle rd
   // while valid=1 consumes it (valid and overrun drop, data_out is kept). rd
   // while valid=0 is ignored. A capture on the same edge as rd takes priority.

   typedef enum logic {
      ST_COUNT   = 1'b0,
      ST_SETTLED = 1'b1
   } db_state_t;

   localparam logic [DB_BITS-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]   sync_s1;
   logic [WIDTH-1:0]   sync_s2;
   logic [WIDTH-1:0]   candidate;
   logic [WIDTH-1:0]   candidate_nxt;
   logic [WIDTH-1:0]   stable;
   logic [WIDTH-1:0]   stable_nxt;
   logic [DB_BITS-1:0] count;
   logic [DB_BITS-1:0] count_nxt;
   db_state_t          state;
   db_state_t          state_nxt;
   logic               settle;
   logic               capture;
   logic [7:0]         candidate_ext;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= i_pins;
         sync_s2 <= sync_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_SETTLED;
         candidate <= '0;
         count     <= '0;
         stable    <= '0;
      end else begin
         state     <= state_nxt;
         candidate <= candidate_nxt;
         count     <= count_nxt;
         stable    <= stable_nxt;
      end
   end

   // Any movement of the synchronized vector restarts the count, whatever the state.
   always_comb begin
      state_nxt     = state;
      candidate_nxt = candidate;
      count_nxt     = count;
      settle        = 1'b0;
      if (sync_s2 != candidate) begin
         candidate_nxt = sync_s2;
         count_nxt     = '0;
         state_nxt     = ST_COUNT;
      end else if (state == ST_COUNT) begin
         if (count != CNT_MAX) begin
            count_nxt = count + DB_BITS'(1);
         end else begin
            state_nxt = ST_SETTLED;
            settle    = 1'b1;
         end
      end
   end

   always_comb begin
      stable_nxt = settle ? candidate : stable;
`ifdef INPORT_PRESS_ONLY_EN
      // Releases still move stable, but only a newly risen bit is reported.
      capture = settle && ((candidate & ~stable) != '0);
`else
      capture = settle && (candidate != stable);
`endif
   end

   always_comb begin
      candidate_ext                = '0;
      candidate_ext[WIDTH-1:0]     = candidate;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= 8'h00;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else if (capture) begin
         data_out <= candidate_ext;
         valid    <= 1'b1;
         // A same-edge read consumed the old byte, so nothing was lost.
         if (valid && !rd) begin
            overrun <= 1'b1;
         end else if (valid && rd) begin
            overrun <= 1'b0;
         end
      end else if (rd && valid) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

   assign dbg_state = (state == ST_SETTLED);

endmodule

// File: tb/tb_cpu_in_port.sv
// Directed bench for cpu_in_port with a 16-cycle debounce window (DB_BITS=4);
// also builds with INPORT_PRESS_ONLY_EN defined.
module tb_cpu_in_port;

   localparam int WIDTH   = 4;
   localparam int DB_BITS = 4;

   typedef struct {
      logic [3:0] pins;
      logic       rd;
      int         cycles;
      logic       cap;
      logic [7:0] data;
      logic       valid;
      logic       ovr;
   } vec_t;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] i_pins;
   logic             rd;
   logic [7:0]       data_out;
   logic             valid;
   logic             overrun;
   logic             dbg_state;

   int         checks;
   int         errors;
   logic [7:0] exp_q[$];
   vec_t       vecs[$];

   cpu_in_port #(.WIDTH(WIDTH), .DB_BITS(DB_BITS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_pins    (i_pins),
      .rd        (rd),
      .data_out  (data_out),
      .valid     (valid),
      .overrun   (overrun),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [7:0] d, input logic v, input logic o);
      check8({name, ".data"}, data_out, d);
      check8({name, ".valid"}, {7'd0, valid}, {7'd0, v});
      check8({name, ".overrun"}, {7'd0, overrun}, {7'd0, o});
   endtask

   // Advance n rising edges; inputs are driven and outputs sampled 1 ns after an edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      if (v.cap) exp_q.push_back(v.data);
      i_pins = v.pins;
      rd     = v.rd;
      tick(1);
      rd = 1'b0;
      if (v.cycles > 1) tick(v.cycles - 1);
      check_outs($sformatf("vec%0d", idx), v.data, v.valid, v.ovr);
   endtask

   // scoreboard: every visible capture must match the head of exp_q
   initial begin
      logic [7:0] prev_data;
      logic       prev_valid;
      logic [7:0] exp_b;
      prev_data  = 8'h00;
      prev_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && ((data_out !== prev_data) || (valid && !prev_valid))) begin
            if (exp_q.size() == 0) begin
               check8("unexpected_capture", data_out, prev_data);
            end else begin
               exp_b = exp_q.pop_front();
               check8("capture_data", data_out, exp_b);
            end
         end
         prev_data  = data_out;
         prev_valid = valid;
      end
   end

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      i_pins  = 4'hF;
      rd      = 1'b0;

      // Pins high through reset: captured 19 edges after release.
      tick(3);
      check_outs("in_reset", 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      exp_q.push_back(8'h0F);
      for (int e = 1; e <= 18; e++) begin
         tick(1);
         check_outs($sformatf("rst_edge%0d", e), 8'h00, 1'b0, 1'b0);
      end
      tick(1);
      check_outs("rst_edge19", 8'h0F, 1'b1, 1'b0);

`ifdef INPORT_PRESS_ONLY_EN
      vecs.push_back('{4'hF, 1'b1,  1, 1'b0, 8'h0F, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0, 19, 1'b0, 8'h0F, 1'b0, 1'b0});
      vecs.push_back('{4'h2, 1'b0, 18, 1'b0, 8'h0F, 1'b0, 1'b0});
      vecs.push_back('{4'h2, 1'b0,  1, 1'b1, 8'h02, 1'b1, 1'b0});
      vecs.push_back('{4'h2, 1'b1,  1, 1'b0, 8'h02, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0, 19, 1'b0, 8'h02, 1'b0, 1'b0});
      vecs.push_back('{4'h4, 1'b0, 18, 1'b0, 8'h02, 1'b0, 1'b0});
      vecs.push_back('{4'h4, 1'b0,  1, 1'b1, 8'h04, 1'b1, 1'b0});
      vecs.push_back('{4'h4, 1'b1,  1, 1'b0, 8'h04, 1'b0, 1'b0});
      vecs.push_back('{4'h6, 1'b0, 19, 1'b1, 8'h06, 1'b1, 1'b0});
      vecs.push_back('{4'h7, 1'b0, 19, 1'b1, 8'h07, 1'b1, 1'b1});
      vecs.push_back('{4'h7, 1'b1,  1, 1'b0, 8'h07, 1'b0, 1'b0});
`else
      vecs.push_back('{4'hF, 1'b1,  1, 1'b0, 8'h0F, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0, 18, 1'b0, 8'h0F, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0,  1, 1'b1, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{4'h0, 1'b1,  1, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h5, 1'b0, 18, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h5, 1'b0,  1, 1'b1, 8'h05, 1'b1, 1'b0});
      vecs.push_back('{4'h5, 1'b1,  1, 1'b0, 8'h05, 1'b0, 1'b0});
      vecs.push_back('{4'h5, 1'b1,  1, 1'b0, 8'h05, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0, 19, 1'b1, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{4'h0, 1'b1,  1, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 1'b0, 10, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 1'b0, 30, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 1'b0, 18, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 1'b0,  1, 1'b1, 8'h01, 1'b1, 1'b0});
      vecs.push_back('{4'h3, 1'b0, 19, 1'b1, 8'h03, 1'b1, 1'b1});
      vecs.push_back('{4'h3, 1'b1,  1, 1'b0, 8'h03, 1'b0, 1'b0});
      vecs.push_back('{4'h7, 1'b0, 19, 1'b1, 8'h07, 1'b1, 1'b0});
      vecs.push_back('{4'h8, 1'b0, 18, 1'b0, 8'h07, 1'b1, 1'b0});
      vecs.push_back('{4'h8, 1'b1,  1, 1'b1, 8'h08, 1'b1, 1'b0});
      vecs.push_back('{4'h8, 1'b1,  1, 1'b0, 8'h08, 1'b0, 1'b0});
`endif
      foreach (vecs[i]) apply_vec(vecs[i], i);

      // Mid-count reset: outputs clear at once and the aborted value never appears.
      apply_vec('{4'h9, 1'b0, 19, 1'b1, 8'h09, 1'b1, 1'b0}, 100);
      i_pins = 4'hA;
      tick(10);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("midcount_reset", 8'h00, 1'b0, 1'b0);
      tick(1);
      reset_n = 1'b1;
      i_pins  = 4'h0;
      for (int c = 0; c < 40; c += 4) begin
         tick(4);
         check_outs($sformatf("post_reset%0d", c), 8'h00, 1'b0, 1'b0);
      end

      tick(2);
      check8("exp_q_empty", 8'(exp_q.size()), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_in_port.md
Name: cpu_in_port

Overview:
- Input-side counterpart to the CPU's LED output port: brings up to 8 raw board inputs (PMOD pins / buttons) into the CPU.
- Each input is synchronized to clk, then the whole input vector is debounced as one value.
- Each debounced change is captured into a byte-wide holding register, and valid is raised.
- The CPU consumes the byte with a one-cycle rd strobe; a lost byte sets a sticky overrun flag.

Parameters:
- WIDTH, 4, number of input pins (1..8); data_out is zero-extended to 8 bits.
- DB_BITS, 18, debounce counter width; the input must be stable for 2^DB_BITS clk cycles (~21.8 ms at 12 MHz).

Ports:
- clk  in  1  system clock (board clock; not the divided CPU clock).
- reset_n  in  1  asynchronous, active-low reset.
- i_pins  in  WIDTH  raw asynchronous inputs.
- rd  in  1  read strobe, single clk cycle, already synchronous to clk (caller edge-detects the CPU-side strobe).
- data_out  out  8  holding register, {zeros, debounced pins}.
- valid  out  1  holding register holds an unread byte.
- overrun  out  1  sticky; an unread byte was overwritten.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port reset_n.
- Reset values (async, while reset_n=0): sync stages 0, candidate 0, counter 0, stable 0, data_out 8'h00, valid 0, overrun 0.
  - Pins already high at reset release are therefore treated as a change and captured after the debounce time.
- Synchronizer: two flops per bit (s1 -> s2); there is no logic between them.
- Debounce, two-state FSM, COUNT / SETTLED:
  - If s2 != candidate: candidate <= s2, counter <= 0, state COUNT. This applies in any state and restarts any count in progress.
  - Else, in COUNT: if counter != 2^DB_BITS-1, counter++; else go to SETTLED.
  - The SETTLED entry cycle performs the capture if candidate != stable: stable <= candidate.
  - SETTLED holds until s2 != candidate.
  - The counter saturates and never wraps.
- Latency:
  - For a clean pin change arriving before clk edge 1, data_out and valid are updated on edge 2^DB_BITS+3.
  - Any glitch shorter than 2^DB_BITS cycles (post-sync) produces no capture.
  - A glitch that returns to the old stable value before settling produces no capture.
- Capture, in the same cycle stable updates: data_out <= {zeros, candidate}, valid <= 1; if valid was already 1 and rd is 0, overrun <= 1.
- Read: rd with valid=1 gives valid <= 0 and overrun <= 0; data_out is held (not cleared).
- Read with valid=0: no effect.
- Simultaneous capture and rd in the same cycle: capture wins. data_out takes the new value, valid stays 1, overrun <= 0 (the old byte was consumed, so nothing was lost).
- Reset asserted mid-count or mid-capture: all state clears immediately; there is no partial update afterwards.
- Only the holding register is visible to the CPU; stable is internal.

Optional Feature:
- Macro INPORT_PRESS_ONLY_EN.
- Defined: capture occurs only if (candidate & ~stable) != 0, i.e. at least one bit rose. stable still tracks all changes, so releases update stable silently (no data_out, valid or overrun change).
- Undefined: every debounced change, rising or falling, is captured.

Test Plan:
- Reset value check: DB_BITS=4, hold reset_n=0 with i_pins=4'hF, then release -> data_out=8'h00, valid=0, overrun=0 through edge 18; on edge 19 data_out=8'h0F, valid=1.
- Clean press plus read: i_pins 0->4'h5 -> valid rises exactly 19 edges later with data_out=8'h05; pulse rd one cycle -> valid=0, data_out stays 8'h05.
- Glitch rejection: 4'h0 -> 4'h1 held 10 cycles -> back to 4'h0 -> no valid, data_out unchanged. Then 4'h1 held 20 cycles -> captured 8'h01.
- Overrun: with valid=1 and no rd, a new debounced value 4'h3 -> data_out=8'h03, overrun=1; rd -> valid=0, overrun=0.
- Simultaneous: assert rd on the exact capture edge of 4'h8 while valid=1 -> data_out=8'h08, valid=1, overrun=0.
- INPORT_PRESS_ONLY_EN: 4'h2 -> captured 8'h02; rd; then 4'h0 -> no valid; then 4'h4 -> captured 8'h04. Mid-count reset_n pulse -> all outputs 0 immediately, no later capture of the aborted value.
